// File: rtl/fpu_issue_ctrl_if.sv
//==============================================================================
// Module   : fpu_issue_ctrl_if
// Desc     : Request, response and FP-unit signal bundle for fpu_issue_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    // Request port
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_opcode;
    logic             req_fmt;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;

    // Response port
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_r;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    // Attached FP unit
    logic [1:0]       fpu_opcode;
    logic             fpu_fmt;
    logic [31:0]      fpu_x;
    logic [31:0]      fpu_y;
    logic [31:0]      fpu_r;

    // Controller side
    modport slave (
        input  req_valid, req_opcode, req_fmt, req_x, req_y, req_tag,
        output req_ready,
        output resp_valid, resp_r, resp_tag, resp_err,
        input  resp_ready,
        output fpu_opcode, fpu_fmt, fpu_x, fpu_y,
        input  fpu_r
    );

    // Requester / FP unit side
    modport master (
        output req_valid, req_opcode, req_fmt, req_x, req_y, req_tag,
        input  req_ready,
        input  resp_valid, resp_r, resp_tag, resp_err,
        output resp_ready,
        input  fpu_opcode, fpu_fmt, fpu_x, fpu_y,
        output fpu_r
    );
endinterface

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
//==============================================================================
// Module   : fpu_issue_ctrl
// Desc     : Issues tagged add/mul ops to an attached FP unit and returns the
//            results in order through a credit-protected result FIFO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_issue_ctrl #(
    parameter int FPU_LAT    = 1,
    parameter int RBUF_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_issue_ctrl_if.slave    bus,
    output logic               busy
);

    localparam int AW    = $clog2(RBUF_DEPTH);
    localparam int OCC_W = $clog2(RBUF_DEPTH + 1);

    // -------------------------------------------------------------------------
    // Credit / occupancy
    // -------------------------------------------------------------------------
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             req_ready;
    logic             accept;
    logic             pop;

    // Ready depends only on registered occupancy, so resp_ready never reaches it.
    assign req_ready     = (occ_q < OCC_W'(RBUF_DEPTH));
    assign bus.req_ready = req_ready;
    assign accept        = bus.req_valid & req_ready;
    assign busy          = (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand registers driving the FP unit
    // -------------------------------------------------------------------------
    logic [1:0]  fpu_opcode_q;
    logic        fpu_fmt_q;
    logic [31:0] fpu_x_q;
    logic [31:0] fpu_y_q;
    logic        issue_fpu;

    // sqrt/div are not handled by the attached unit, so its inputs are left alone.
    assign issue_fpu = accept & ~bus.req_opcode[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_opcode_q <= 2'b00;
            fpu_fmt_q    <= 1'b0;
            fpu_x_q      <= 32'h0;
            fpu_y_q      <= 32'h0;
        end else if (issue_fpu) begin
            fpu_opcode_q <= bus.req_opcode;
            fpu_fmt_q    <= bus.req_fmt;
            fpu_x_q      <= bus.req_x;
            fpu_y_q      <= bus.req_y;
        end
    end

    assign bus.fpu_opcode = fpu_opcode_q;
    assign bus.fpu_fmt    = fpu_fmt_q;
    assign bus.fpu_x      = fpu_x_q;
    assign bus.fpu_y      = fpu_y_q;

    // -------------------------------------------------------------------------
    // Latency-matching pipe: {valid, tag, err} per stage
    // -------------------------------------------------------------------------
    logic [FPU_LAT-1:0]            pipe_vld_q;
    logic [FPU_LAT-1:0]            pipe_err_q;
    logic [FPU_LAT-1:0][TAG_W-1:0] pipe_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_err_q[0] <= bus.req_opcode[1];
            pipe_tag_q[0] <= bus.req_tag;
            for (int i = 1; i < FPU_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO
    // -------------------------------------------------------------------------
    logic [31:0]      mem_r_q   [RBUF_DEPTH];
    logic [TAG_W-1:0] mem_tag_q [RBUF_DEPTH];
    logic             mem_err_q [RBUF_DEPTH];

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             wr_err;
    logic [31:0]      wr_r;
    logic [TAG_W-1:0] wr_tag;
    logic             fifo_empty;
    logic             fifo_full;

    assign wr_en  = pipe_vld_q[FPU_LAT-1];
    assign wr_err = pipe_err_q[FPU_LAT-1];
    assign wr_tag = pipe_tag_q[FPU_LAT-1];
    assign wr_r   = wr_err ? 32'h0 : bus.fpu_r;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop = ~fifo_empty & bus.resp_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r_q[wr_ptr_q[AW-1:0]]   <= wr_r;
            mem_tag_q[wr_ptr_q[AW-1:0]] <= wr_tag;
            mem_err_q[wr_ptr_q[AW-1:0]] <= wr_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Head fields are forced to zero while empty so reset/idle outputs are clean.
    assign bus.resp_valid = ~fifo_empty;
    assign bus.resp_r     = fifo_empty ? 32'h0        : mem_r_q[rd_ptr_q[AW-1:0]];
    assign bus.resp_tag   = fifo_empty ? {TAG_W{1'b0}} : mem_tag_q[rd_ptr_q[AW-1:0]];
    assign bus.resp_err   = fifo_empty ? 1'b0         : mem_err_q[rd_ptr_q[AW-1:0]];

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(wr_en && fifo_full && !pop)
    );

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
//==============================================================================
// Module   : tb_fpu_issue_ctrl
// Desc     : Randomized and directed bench for fpu_issue_ctrl with a queue model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fpu_issue_ctrl;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    fpu_issue_ctrl_if #(.TAG_W(TW)) bus ();

    fpu_issue_ctrl #(
        .FPU_LAT    (LAT),
        .RBUF_DEPTH (DEPTH),
        .TAG_W      (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple FP32 add/mul unit built on double-precision arithmetic
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_calc(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
        case (op)
            2'b00:   return r2f(f2r(x) + f2r(y));
            2'b01:   return r2f(f2r(x) * f2r(y));
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.fpu_r = fpu_calc(bus.fpu_opcode, bus.fpu_x, bus.fpu_y);

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Reference model: outstanding ops in acceptance order, each with the cycle
    // count at which it must first be visible at the response port.
    typedef struct {
        logic [31:0]   r;
        logic [TW-1:0] tag;
        logic          err;
        int            vis;
    } exp_t;

    exp_t        q[$];
    logic [1:0]  m_op;
    logic        m_fmt;
    logic [31:0] m_x;
    logic [31:0] m_y;

    int n_cmp   = 0;
    int n_mis   = 0;
    int obs_acc = 0;
    int obs_pop = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rv();
        return (q.size() > 0) && (q[0].vis <= cyc);
    endfunction

    task automatic check_outputs();
        check_eq("req_ready",  bus.req_ready,  q.size() < DEPTH);
        check_eq("busy",       busy,           q.size() != 0);
        check_eq("resp_valid", bus.resp_valid, model_rv());
        if (model_rv()) begin
            check_eq("resp_r",   bus.resp_r,   q[0].r);
            check_eq("resp_tag", bus.resp_tag, q[0].tag);
            check_eq("resp_err", bus.resp_err, q[0].err);
        end
        check_eq("fpu_opcode", bus.fpu_opcode, m_op);
        check_eq("fpu_fmt",    bus.fpu_fmt,    m_fmt);
        check_eq("fpu_x",      bus.fpu_x,      m_x);
        check_eq("fpu_y",      bus.fpu_y,      m_y);
    endtask

    // Called at a falling edge: check, drive, advance the model, wait one cycle.
    task automatic drive_cycle(input bit v, input logic [1:0] op, input bit fmt,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [TW-1:0] tag, input bit rr, output bit acc);
        bit   rv;
        exp_t e;
        check_outputs();
        rv             = model_rv();
        bus.req_valid  = v;
        bus.req_opcode = op;
        bus.req_fmt    = fmt;
        bus.req_x      = x;
        bus.req_y      = y;
        bus.req_tag    = tag;
        bus.resp_ready = rr;
        if (bus.req_valid && bus.req_ready) obs_acc++;
        if (bus.resp_valid && bus.resp_ready) obs_pop++;
        acc = v && (q.size() < DEPTH);
        if (rr && rv) void'(q.pop_front());
        if (acc) begin
            e.r   = op[1] ? 32'd0 : fpu_calc(op, x, y);
            e.tag = tag;
            e.err = op[1];
            e.vis = cyc + 1 + LAT;
            q.push_back(e);
            if (!op[1]) begin
                m_op  = op;
                m_fmt = fmt;
                m_x   = x;
                m_y   = y;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rr);
        bit a;
        drive_cycle(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, '0, rr, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        check_eq({tag, "_resp_r"},     bus.resp_r,     32'd0);
        check_eq({tag, "_resp_tag"},   bus.resp_tag,   '0);
        check_eq({tag, "_resp_err"},   bus.resp_err,   1'b0);
        check_eq({tag, "_fpu"},        {bus.fpu_opcode, bus.fpu_fmt, bus.fpu_x, bus.fpu_y}, '0);
        check_eq({tag, "_busy"},       busy,           1'b0);
        check_eq({tag, "_req_ready"},  bus.req_ready,  1'b1);
    endtask

    initial begin
        bit              a;
        int              idx;
        int              acc0;
        int              pop0;
        bit              v;
        logic [1:0]      op;
        bit              fmt;
        logic [31:0]     x;
        logic [31:0]     y;
        logic [TW-1:0]   tag;
        int              r;

        bus.req_valid  = 1'b0;
        bus.req_opcode = 2'b00;
        bus.req_fmt    = 1'b0;
        bus.req_x      = 32'd0;
        bus.req_y      = 32'd0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        m_op = 2'b00; m_fmt = 1'b0; m_x = 32'd0; m_y = 32'd0;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: add
        drive_cycle(1'b1, 2'b00, 1'b0, 32'h3F800000, 32'h40000000, 4'd1, 1'b0, a);
        idle(1'b0);
        check_eq("t1_valid", bus.resp_valid, 1'b1);
        check_eq("t1_r",     bus.resp_r,     32'h40400000);
        check_eq("t1_tag",   bus.resp_tag,   4'd1);
        check_eq("t1_err",   bus.resp_err,   1'b0);
        idle(1'b1);

        // 2: mul
        drive_cycle(1'b1, 2'b01, 1'b0, 32'h40000000, 32'h40400000, 4'd2, 1'b0, a);
        check_eq("t2_fpu_opcode", bus.fpu_opcode, 2'b01);
        idle(1'b0);
        check_eq("t2_r",   bus.resp_r,   32'h40C00000);
        check_eq("t2_err", bus.resp_err, 1'b0);
        idle(1'b1);

        // 3: unsupported opcode
        drive_cycle(1'b1, 2'b10, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd3, 1'b0, a);
        idle(1'b0);
        check_eq("t3_r",     bus.resp_r,   32'd0);
        check_eq("t3_err",   bus.resp_err, 1'b1);
        check_eq("t3_tag",   bus.resp_tag, 4'd3);
        check_eq("t3_fpu_x", bus.fpu_x,    32'h40000000);
        check_eq("t3_fpu_y", bus.fpu_y,    32'h40400000);
        idle(1'b1);

        // 4: credit exhaustion with responses stalled
        idx = 0;
        x = rand_fp(); y = rand_fp();
        for (int n = 0; n < 6; n++) begin
            drive_cycle(1'b1, 2'b00, 1'b0, x, y, TW'(idx), 1'b0, a);
            if (a) begin idx++; x = rand_fp(); y = rand_fp(); end
        end
        check_eq("t4_accepted", idx, 4);
        check_eq("t4_ready",    bus.req_ready, 1'b0);
        check_eq("t4_busy",     busy,          1'b1);
        for (int n = 0; n < 30 && (idx < 5 || q.size() > 0); n++) begin
            drive_cycle(idx < 5, 2'b00, 1'b0, x, y, TW'(idx), 1'b1, a);
            if (a) begin idx++; x = rand_fp(); y = rand_fp(); end
        end
        check_eq("t4_tag4_accepted", idx, 5);
        check_eq("t4_drain_timeout", q.size(), 0);

        // 5: streaming
        acc0 = obs_acc;
        pop0 = obs_pop;
        for (int n = 0; n < 20; n++) begin
            drive_cycle(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), rand_fp(), rand_fp(),
                        TW'(n), 1'b1, a);
        end
        check_eq("t5_accepts", obs_acc - acc0, 20);
        check_eq("t5_pops",    obs_pop - pop0, 18);
        repeat (3) idle(1'b1);

        // 6: reset with ops outstanding
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b1, 2'b01, 1'b1, rand_fp(), rand_fp(), TW'(n + 8), 1'b0, a);
        end
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_rst");
        q.delete();
        m_op = 2'b00; m_fmt = 1'b0; m_x = 32'd0; m_y = 32'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        repeat (4) idle(1'b1);

        // Random traffic, holding an unaccepted request stable
        v = 1'b0; op = 2'b00; fmt = 1'b0; x = 32'd0; y = 32'd0; tag = '0;
        for (int n = 0; n < 400; n++) begin
            if (!v || a) begin
                v   = ($urandom_range(0, 9) < 7);
                r   = $urandom_range(0, 9);
                op  = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : {1'b1, 1'($urandom)};
                fmt = 1'($urandom);
                x   = rand_fp();
                y   = rand_fp();
                tag = TW'($urandom);
            end
            drive_cycle(v, op, fmt, x, y, tag, ($urandom_range(0, 9) < 6), a);
        end
        for (int n = 0; n < 20 && q.size() > 0; n++) idle(1'b1);
        check_eq("rand_drain_timeout", q.size(), 0);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
